// File: rtl/ahb_multiregion_subordinate_if.sv
// AHB-Lite bus plus bus_protocol request channel for the multi-region subordinate.
// The slave modport is the subordinate's view; the master modport is the surrounding system.
interface ahb_multiregion_subordinate_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RIDX_W     = 2
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  HSEL;
    logic                  HREADY;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [STRB_W-1:0]     HWSTRB;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [RIDX_W-1:0]     bus_region;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [STRB_W-1:0]     bus_strobe;
    logic                  bus_wen;
    logic                  bus_ren;
    logic                  bus_is_burst;
    logic [1:0]            bus_burst_type;
    logic [4:0]            bus_burst_length;
    logic                  bus_burst_last;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_request_stall;
    logic                  bus_error;

    modport slave (
        input  HSEL, HREADY, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HWSTRB,
        output HRDATA, HREADYOUT, HRESP,
        output bus_addr, bus_region, bus_wdata, bus_strobe, bus_wen, bus_ren,
        output bus_is_burst, bus_burst_type, bus_burst_length, bus_burst_last,
        input  bus_rdata, bus_request_stall, bus_error
    );

    modport master (
        output HSEL, HREADY, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HWSTRB,
        input  HRDATA, HREADYOUT, HRESP,
        input  bus_addr, bus_region, bus_wdata, bus_strobe, bus_wen, bus_ren,
        input  bus_is_burst, bus_burst_type, bus_burst_length, bus_burst_last,
        output bus_rdata, bus_request_stall, bus_error
    );
endinterface

// File: rtl/ahb_multiregion_subordinate.sv
// AHB-Lite subordinate decoding NREGIONS windows onto a bus_protocol request port.
// Define ALIGN_CHECK_EN to also reject misaligned or oversized transfers with an ERROR response.
//
// state  | meaning
// IDLE   | no data phase in progress, zero-wait OKAY
// ACCESS | data phase on bus_protocol, waits on bus_request_stall
// ERR1   | first ERROR cycle (HREADYOUT=0)
// ERR2   | second ERROR cycle (HREADYOUT=1), may accept a new transfer
module ahb_multiregion_subordinate #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h8000_0000,
    parameter int                    NREGIONS     = 4,
    parameter int                    REGION_BYTES = 'h1000,
    parameter logic [NREGIONS-1:0]   REGION_EN    = '1
) (
    input  logic HCLK_i,
    input  logic HRESET_i,
    ahb_multiregion_subordinate_if.slave sub_if
);
    localparam int RIDX_W = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;
    localparam int OFS_W  = $clog2(REGION_BYTES);
    localparam int IDX_W  = ADDR_WIDTH - OFS_W;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [RIDX_W-1:0]     region_q;
    logic                  write_q;
    logic [2:0]            burst_q;
    logic [4:0]            beat_cnt_q;

    logic                  accept, capture, decode_err, base_err;
    logic [ADDR_WIDTH-1:0] rel_addr;
    logic [IDX_W-1:0]      idx_full;
    logic [RIDX_W-1:0]     region_idx;
    logic                  hreadyout, hresp, wen, ren;
    logic [DATA_WIDTH-1:0] hrdata;
    logic [4:0]            burst_len;

    assign accept     = sub_if.HSEL & sub_if.HREADY & sub_if.HTRANS[1];
    assign rel_addr   = sub_if.HADDR - BASE_ADDR;
    assign idx_full   = rel_addr[ADDR_WIDTH-1:OFS_W];
    assign region_idx = idx_full[RIDX_W-1:0];
    // Range is checked on the full index so aliasing of upper bits cannot hit a window.
    assign base_err   = (sub_if.HADDR < BASE_ADDR)
                      | (idx_full >= IDX_W'(NREGIONS))
                      | ~REGION_EN[region_idx];

`ifdef ALIGN_CHECK_EN
    logic [ADDR_WIDTH-1:0] size_mask;
    logic                  misaligned;
    assign size_mask  = ~({ADDR_WIDTH{1'b1}} << sub_if.HSIZE);
    assign misaligned = (|(sub_if.HADDR & size_mask))
                      | (sub_if.HSIZE > 3'($clog2(DATA_WIDTH / 8)));
    assign decode_err = base_err | misaligned;
`else
    assign decode_err = base_err;
`endif

    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        wen       = 1'b0;
        ren       = 1'b0;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                capture = accept;
                if (accept) state_d = decode_err ? S_ERR1 : S_ACCESS;
            end
            S_ACCESS: begin
                wen = write_q;
                ren = ~write_q;
                if (sub_if.bus_request_stall) begin
                    hreadyout = 1'b0;
                end else if (sub_if.bus_error) begin
                    hreadyout = 1'b0;
                    hresp     = 1'b1;
                    state_d   = S_ERR2;
                end else begin
                    hrdata  = write_q ? '0 : sub_if.bus_rdata;
                    capture = accept;
                    state_d = accept ? (decode_err ? S_ERR1 : S_ACCESS) : S_IDLE;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp   = 1'b1;
                capture = accept;
                state_d = accept ? (decode_err ? S_ERR1 : S_ACCESS) : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK_i) begin
        if (HRESET_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            region_q   <= '0;
            write_q    <= 1'b0;
            burst_q    <= 3'b000;
            beat_cnt_q <= 5'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q   <= {{IDX_W{1'b0}}, rel_addr[OFS_W-1:0]};
                region_q <= region_idx;
                write_q  <= sub_if.HWRITE;
                burst_q  <= sub_if.HBURST;
                if (sub_if.HTRANS[0])
                    beat_cnt_q <= (beat_cnt_q == 5'd16) ? 5'd16 : beat_cnt_q + 5'd1;
                else
                    beat_cnt_q <= 5'd1;
            end
        end
    end

    // HBURST[2:1] selects 4/8/16 beats; odd encodings are INCR*, even non-zero are WRAP*.
    always_comb begin
        case (burst_q[2:1])
            2'b01:   burst_len = 5'd4;
            2'b10:   burst_len = 5'd8;
            2'b11:   burst_len = 5'd16;
            default: burst_len = 5'd0;
        endcase
    end

    assign sub_if.HREADYOUT        = hreadyout;
    assign sub_if.HRESP            = hresp;
    assign sub_if.HRDATA           = hrdata;
    assign sub_if.bus_wen          = wen;
    assign sub_if.bus_ren          = ren;
    assign sub_if.bus_addr         = addr_q;
    assign sub_if.bus_region       = region_q;
    assign sub_if.bus_wdata        = wen ? sub_if.HWDATA : '0;
    assign sub_if.bus_strobe       = wen ? sub_if.HWSTRB : '0;
    assign sub_if.bus_is_burst     = (burst_q != 3'b000);
    assign sub_if.bus_burst_type   = (burst_q == 3'b000) ? 2'b00 : (burst_q[0] ? 2'b10 : 2'b11);
    assign sub_if.bus_burst_length = burst_len;
    assign sub_if.bus_burst_last   = (beat_cnt_q == burst_len) && (burst_len != 5'd0);
endmodule

// File: tb/tb_ahb_multiregion_subordinate.sv
// Directed and random checks of ahb_multiregion_subordinate against an address-map reference model.
module tb_ahb_multiregion_subordinate;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned RB   = 32'h1000;
    localparam int          NREG = 4;
    localparam logic [3:0]  EN   = 4'b1011;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks = 0;
    int   errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_multiregion_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RIDX_W(2)) ifc ();

    ahb_multiregion_subordinate #(.REGION_EN(EN)) dut (
        .HCLK_i   (HCLK),
        .HRESET_i (HRESET),
        .sub_if   (ifc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    // Address map reference: window index and offset by plain division.
    function automatic void model_decode(input logic [31:0] a, input logic [2:0] size,
                                         output bit err, output int region, output logic [31:0] ofs);
        err = 0; region = 0; ofs = 0;
        if (a < BASE) err = 1;
        else begin
            region = int'((a - BASE) / RB);
            ofs    = (a - BASE) % RB;
            if (region >= NREG) err = 1;
            else if (!EN[region]) err = 1;
        end
`ifdef ALIGN_CHECK_EN
        if ((a % (32'd1 << size)) != 0 || size > 3'd2) err = 1;
`endif
    endfunction

    task automatic bus_idle();
        ifc.HSEL = 0; ifc.HREADY = 1; ifc.HTRANS = 2'b00; ifc.HBURST = 3'b000;
        ifc.bus_request_stall = 0; ifc.bus_error = 0;
    endtask

    task automatic check_quiet(input string tag);
        sample();
        chk({tag, "_rdy"}, ifc.HREADYOUT, 1);
        chk({tag, "_resp"}, ifc.HRESP, 0);
        chk({tag, "_strb"}, {ifc.bus_wen, ifc.bus_ren, ifc.HRDATA}, 0);
    endtask

    task automatic run_single(input logic [31:0] a, input bit wr, input logic [2:0] size,
                              input int stalls, input bit berr,
                              input logic [31:0] wd, input logic [31:0] rd);
        bit err; int region; logic [31:0] ofs;
        model_decode(a, size, err, region, ofs);
        ifc.HSEL = 1; ifc.HREADY = 1; ifc.HTRANS = 2'b10; ifc.HADDR = a;
        ifc.HWRITE = wr; ifc.HSIZE = size; ifc.HBURST = 3'b000;
        sample();
        chk("aphase_rdy", ifc.HREADYOUT, 1);
        step();
        ifc.HSEL = 0; ifc.HTRANS = 2'b00; ifc.HWDATA = wd; ifc.HWSTRB = 4'hF; ifc.bus_rdata = rd;
        if (err) begin
            sample();
            chk("err1", {ifc.HREADYOUT, ifc.HRESP, ifc.bus_wen, ifc.bus_ren}, 4'b0100);
            step();
            sample();
            chk("err2", {ifc.HREADYOUT, ifc.HRESP, ifc.bus_wen, ifc.bus_ren}, 4'b1100);
            step();
        end else begin
            for (int s = 0; s < stalls; s++) begin
                ifc.bus_request_stall = 1;
                sample();
                chk("stall", {ifc.HREADYOUT, ifc.HRESP, ifc.bus_wen, ifc.bus_ren}, {2'b00, wr, !wr});
                step();
            end
            ifc.bus_request_stall = 0; ifc.bus_error = berr;
            sample();
            chk("bus_addr", ifc.bus_addr, ofs);
            chk("bus_region", ifc.bus_region, region);
            chk("strobes", {ifc.bus_wen, ifc.bus_ren}, {wr, !wr});
            if (berr) begin
                chk("berr1", {ifc.HREADYOUT, ifc.HRESP, ifc.HRDATA}, {2'b01, 32'h0});
                step();
                ifc.bus_error = 0;
                sample();
                chk("berr2", {ifc.HREADYOUT, ifc.HRESP, ifc.bus_wen, ifc.bus_ren}, 4'b1100);
            end else begin
                chk("done", {ifc.HREADYOUT, ifc.HRESP}, 2'b10);
                chk("hrdata", ifc.HRDATA, wr ? 32'h0 : rd);
                if (wr) chk("wdata", {ifc.bus_wdata, ifc.bus_strobe}, {wd, 4'hF});
            end
            step();
        end
        check_quiet("after");
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] trans [7];
        logic [31:0] rdq [7];
        int accepted, prev_beat;
        bit prev_acc;

        ifc.HADDR = 0; ifc.HWRITE = 0; ifc.HSIZE = 3'd2; ifc.HWDATA = 0; ifc.HWSTRB = 0;
        ifc.bus_rdata = 0;
        bus_idle();
        HRESET = 1;
        step(); step();
        sample();
        chk("rst_rdy_resp", {ifc.HREADYOUT, ifc.HRESP, ifc.HRDATA}, {2'b10, 32'h0});
        chk("rst_bus", {ifc.bus_wen, ifc.bus_ren, ifc.bus_is_burst, ifc.bus_burst_type,
                        ifc.bus_burst_length, ifc.bus_burst_last, ifc.bus_region}, 0);
        chk("rst_addr", ifc.bus_addr, 0);
        step();
        HRESET = 0;
        step();

        run_single(32'h8000_0010, 1, 3'd2, 0, 0, 32'hDEAD_BEEF, 32'h0);
        run_single(32'h8000_1004, 0, 3'd2, 3, 0, 32'h0, 32'h1234_5678);
        run_single(32'h7FFF_FFFC, 0, 3'd2, 0, 0, 32'h0, 32'h0);
        run_single(32'h8000_2000, 1, 3'd2, 0, 0, 32'h1, 32'h0);
        run_single(32'h8000_4000, 0, 3'd2, 1, 0, 32'h0, 32'h0);
        run_single(32'h8000_3008, 1, 3'd2, 1, 1, 32'hCAFE_F00D, 32'h0);
        run_single(32'h8000_0002, 0, 3'd2, 0, 0, 32'h0, 32'hA5A5_0002);

        // INCR4 read with one BUSY after beat 2.
        trans = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
        accepted = 0; prev_acc = 0; prev_beat = 0;
        ifc.HWRITE = 0; ifc.HBURST = 3'b011; ifc.HSIZE = 3'd2;
        for (int c = 0; c < 7; c++) begin
            rdq[c] = $urandom;
            ifc.HTRANS = trans[c];
            ifc.HSEL = (trans[c] != 2'b00);
            ifc.HADDR = 32'h8000_0100 + 32'(4 * accepted);
            ifc.bus_rdata = rdq[c];
            sample();
            if (prev_acc) begin
                chk("burst_ren", {ifc.bus_ren, ifc.bus_wen, ifc.HREADYOUT}, 3'b101);
                chk("burst_len", ifc.bus_burst_length, 4);
                chk("burst_type", {ifc.bus_is_burst, ifc.bus_burst_type}, 3'b110);
                chk("burst_last", ifc.bus_burst_last, prev_beat == 4);
                chk("burst_addr", ifc.bus_addr, 32'h100 + 32'(4 * (prev_beat - 1)));
                chk("burst_rdata", ifc.HRDATA, rdq[c]);
            end else begin
                chk("burst_gap", {ifc.bus_ren, ifc.bus_wen, ifc.HREADYOUT}, 3'b001);
            end
            prev_acc = trans[c][1];
            if (prev_acc) begin
                accepted++;
                prev_beat = accepted;
            end
            step();
        end
        bus_idle();

        // Back-to-back write to region 3 then read of region 0.
        ifc.HSEL = 1; ifc.HTRANS = 2'b10; ifc.HADDR = 32'h8000_3020; ifc.HWRITE = 1;
        sample();
        chk("b2b_a_rdy", ifc.HREADYOUT, 1);
        step();
        ifc.HADDR = 32'h8000_0040; ifc.HWRITE = 0; ifc.HWDATA = 32'h0BAD_CAFE; ifc.HWSTRB = 4'h3;
        sample();
        chk("b2b_wr", {ifc.bus_wen, ifc.bus_ren, ifc.bus_region, ifc.bus_addr}, {2'b10, 2'd3, 32'h20});
        chk("b2b_wdata", {ifc.bus_wdata, ifc.bus_strobe}, {32'h0BAD_CAFE, 4'h3});
        step();
        bus_idle();
        ifc.bus_rdata = 32'h7777_1111;
        sample();
        chk("b2b_rd", {ifc.bus_wen, ifc.bus_ren, ifc.bus_region, ifc.bus_addr}, {2'b01, 2'd0, 32'h40});
        chk("b2b_rdata", ifc.HRDATA, 32'h7777_1111);
        step();
        check_quiet("b2b_end");
        step();

        // Randomized single transfers across windows, holes and out-of-range addresses.
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 6));
            case (kind)
                0:       a = BASE - 32'(4 * $urandom_range(1, 64));
                5:       a = BASE + 32'(RB * $urandom_range(4, 9)) + 32'(4 * $urandom_range(0, 1023));
                6:       a = BASE + 32'($urandom_range(0, 4095));
                default: a = BASE + 32'(RB * (kind - 1)) + 32'(4 * $urandom_range(0, 1023));
            endcase
            run_single(a, 1'($urandom_range(0, 1)), 3'd2, int'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0), $urandom, $urandom);
        end

        // Reset in the middle of a stalled write.
        ifc.HSEL = 1; ifc.HTRANS = 2'b10; ifc.HADDR = 32'h8000_0008; ifc.HWRITE = 1;
        step();
        bus_idle();
        ifc.bus_request_stall = 1;
        sample();
        chk("mid_wen", ifc.bus_wen, 1);
        step();
        HRESET = 1;
        step();
        HRESET = 0;
        sample();
        chk("post_rst", {ifc.bus_wen, ifc.bus_ren, ifc.HREADYOUT, ifc.HRESP}, 4'b0010);
        chk("post_rst_addr", ifc.bus_addr, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
